// File: rtl/submod_arb_if.sv
// submod_arb_if: request/response bundle between the ladder-step sequencers
// (master side) and the arbitrated modular subtractor front end (slave side).
// Operand packing: requester i uses bits [448*i+447 : 448*i] of req_a/req_b.
interface submod_arb_if #(
  parameter int NREQ = 4,
  parameter int TAGW = 2
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*448-1:0] req_a;
  logic [NREQ*448-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [TAGW-1:0]     rsp_tag;
  logic [447:0]        rsp_z;
  logic                busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_tag, rsp_z, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_tag, rsp_z, busy
  );
endinterface

// File: rtl/submod_arb.sv
// submod_arb: NREQ requesters share one 448-bit subtractor computing
// z = (a - b) mod p, p = 2^448 - 2^224 - 1, through a two-stage pipeline
// (S1 operands, S2 result). Responses leave in acceptance order, tagged with
// the requester index.
// Build option: define SUBMOD_ARB_RR_EN for round-robin arbitration; without
// it the lowest valid index always wins and no pointer is built.
module submod_arb #(
  parameter int NREQ = 4,
  parameter int TAGW = 2
) (
  input  logic          clk,
  input  logic          resetn,
  submod_arb_if.slave   bus
);

  // p = all ones except bit 224
  localparam logic [447:0] P = {{223{1'b1}}, 1'b0, {224{1'b1}}};

  logic            s1_valid_reg;
  logic [447:0]    s1_a_reg;
  logic [447:0]    s1_b_reg;
  logic [TAGW-1:0] s1_tag_reg;
  logic            s2_valid_reg;
  logic [447:0]    s2_z_reg;
  logic [TAGW-1:0] s2_tag_reg;

  logic            advance;
  logic            gnt_valid;
  logic [TAGW-1:0] gnt_idx;
  logic [447:0]    gnt_a;
  logic [447:0]    gnt_b;
  logic            accept;
  logic [448:0]    diff;
  logic [447:0]    sub_z;

  // Both stages move together; a full S2 that is not being drained freezes everything.
  assign advance = !s2_valid_reg || bus.rsp_ready;
  assign accept  = advance && gnt_valid;

`ifdef SUBMOD_ARB_RR_EN
  logic [TAGW-1:0] ptr_reg;
  int              best_d;

  // Round-robin grant: the valid requester closest after the last accepted index wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    best_d    = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && (((i + NREQ - 1 - int'(ptr_reg)) % NREQ) < best_d)) begin
        best_d    = (i + NREQ - 1 - int'(ptr_reg)) % NREQ;
        gnt_valid = 1'b1;
        gnt_idx   = TAGW'(i);
      end
    end
  end

  // Pointer follows accepted handshakes only; a stalled grant leaves it alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_reg <= TAGW'(NREQ - 1);
    end else if (accept) begin
      ptr_reg <= gnt_idx;
    end
  end
`else
  // Fixed-priority grant: the lowest valid index wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        gnt_valid = 1'b1;
        gnt_idx   = TAGW'(i);
      end
    end
  end
`endif

  // Operand mux for the granted requester.
  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == TAGW'(i)) begin
        gnt_a = bus.req_a[448*i +: 448];
        gnt_b = bus.req_b[448*i +: 448];
      end
    end
  end

  // Ready goes only to the granted requester, and never while in reset.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign bus.req_ready[gi] = resetn && accept && (gnt_idx == TAGW'(gi));
    end
  endgenerate

  // Subtract with borrow; on borrow add p back (wraps mod 2^448 for canonical inputs).
  assign diff  = {1'b0, s1_a_reg} - {1'b0, s1_b_reg};
  assign sub_z = diff[448] ? (diff[447:0] + P) : diff[447:0];

  // Pipeline registers; reset flushes both stages immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_tag_reg   <= '0;
      s2_valid_reg <= 1'b0;
      s2_z_reg     <= '0;
      s2_tag_reg   <= '0;
    end else if (advance) begin
      s1_valid_reg <= gnt_valid;
      if (gnt_valid) begin
        s1_a_reg   <= gnt_a;
        s1_b_reg   <= gnt_b;
        s1_tag_reg <= gnt_idx;
      end
      s2_valid_reg <= s1_valid_reg;
      s2_z_reg     <= sub_z;
      s2_tag_reg   <= s1_tag_reg;
    end
  end

  assign bus.rsp_valid = s2_valid_reg;
  assign bus.rsp_tag   = s2_tag_reg;
  assign bus.rsp_z     = s2_z_reg;
  assign bus.busy      = s1_valid_reg || s2_valid_reg;

endmodule

// File: tb/tb_submod_arb.sv
// tb_submod_arb: directed and randomized checks of submod_arb against a
// transaction-level model: a queue of outstanding results, each becoming
// visible two edges after acceptance or on the edge its predecessor leaves.
// Honours SUBMOD_ARB_RR_EN the same way as the design.
module tb_submod_arb;
  localparam int NREQ = 4;
  localparam int TAGW = 2;
  localparam logic [447:0] P = {{223{1'b1}}, 1'b0, {224{1'b1}}};

  typedef struct {
    logic [TAGW-1:0] tag;
    logic [447:0]    z;
    int              vmin;
    int              vis;
  } ent_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [NREQ-1:0] rv = '0;
  logic [447:0] ra [NREQ];
  logic [447:0] rb [NREQ];
  logic rr = 1'b1;

  ent_t q[$];
  bit   pend [NREQ];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   in_withdraw = 1'b0;
  int   seen_tag1 = 0;
`ifdef SUBMOD_ARB_RR_EN
  int   last = NREQ - 1;
`endif

  always #5 clk = ~clk;

  submod_arb_if #(.NREQ(NREQ), .TAGW(TAGW)) bus ();

  submod_arb #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  assign bus.req_valid = rv;
  assign bus.rsp_ready = rr;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[448*i +: 448] = ra[i];
      bus.req_b[448*i +: 448] = rb[i];
    end
  end

  task automatic chk(input string tag, input logic [447:0] got, input logic [447:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // (a - b) mod p via a + p - b, reduced once
  function automatic logic [447:0] ref_sub(input logic [447:0] a, input logic [447:0] b);
    logic [449:0] t;
    t = {2'b00, a} + {2'b00, P} - {2'b00, b};
    if (t >= {2'b00, P}) t = t - {2'b00, P};
    return t[447:0];
  endfunction

  function automatic logic [447:0] rnd_fe();
    logic [447:0] x;
    int s;
    s = $urandom_range(7);
    for (int k = 0; k < 14; k++) x[32*k +: 32] = $urandom();
    if (s == 0) x = 448'($urandom_range(15));
    else if (s == 1) x = P - 448'(1 + $urandom_range(15));
    if (x >= P) x = x - P;
    return x;
  endfunction

`ifdef SUBMOD_ARB_RR_EN
  function automatic int pick(input logic [NREQ-1:0] v, input int lst);
    for (int k = 1; k <= NREQ; k++) begin
      if (((v >> ((lst + k) % NREQ)) & NREQ'(1)) != '0) return (lst + k) % NREQ;
    end
    return -1;
  endfunction
`else
  function automatic int pick(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction
`endif

  task automatic drive_pend();
    for (int i = 0; i < NREQ; i++) rv[i] = pend[i];
  endtask

  // One clock: check outputs at the falling edge, advance the model, return 1 time unit after the rising edge.
  task automatic step();
    bit hv;
    bit adv;
    int w;
    logic [NREQ-1:0] er;
    ent_t e;
    @(negedge clk);
    hv  = (q.size() > 0) && (q[0].vis <= cyc);
    adv = !hv || rr;
`ifdef SUBMOD_ARB_RR_EN
    w = pick(rv, last);
`else
    w = pick(rv);
`endif
    er = '0;
    if (adv && w >= 0) er = NREQ'(1) << w;
    chk("rsp_valid", 448'(bus.rsp_valid), 448'(hv));
    if (hv) begin
      chk("rsp_tag", 448'(bus.rsp_tag), 448'(q[0].tag));
      chk("rsp_z", bus.rsp_z, q[0].z);
    end
    chk("busy", 448'(bus.busy), 448'(q.size() > 0));
    chk("req_ready", 448'(bus.req_ready), 448'(er));
    if (in_withdraw && bus.rsp_valid && bus.rsp_tag == TAGW'(1)) seen_tag1++;
    if (hv && rr) begin
      void'(q.pop_front());
      if (q.size() > 0) q[0].vis = (q[0].vmin > cyc + 1) ? q[0].vmin : cyc + 1;
    end
    if (adv && w >= 0) begin
      e.tag  = TAGW'(w);
      e.z    = ref_sub(ra[w], rb[w]);
      e.vmin = cyc + 2;
      e.vis  = (q.size() == 0) ? cyc + 2 : (1 << 30);
      q.push_back(e);
      pend[w] = 1'b0;
`ifdef SUBMOD_ARB_RR_EN
      last = w;
`endif
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic issue(input int i, input logic [447:0] a, input logic [447:0] b);
    ra[i] = a;
    rb[i] = b;
    rv = NREQ'(1) << i;
    step();
    rv = '0;
  endtask

  initial begin
    logic [447:0] pm1;
    logic [447:0] pm2;
    pm1 = P - 448'd1;
    pm2 = P - 448'd2;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = '0;
      rb[i] = '0;
      pend[i] = 1'b0;
    end

    // Reset values, with every requester asking
    @(posedge clk);
    @(posedge clk);
    #1;
    rv = '1;
    #1;
    chk("rst_rsp_valid", 448'(bus.rsp_valid), 448'd0);
    chk("rst_busy", 448'(bus.busy), 448'd0);
    chk("rst_rsp_tag", 448'(bus.rsp_tag), 448'd0);
    chk("rst_rsp_z", bus.rsp_z, 448'd0);
    chk("rst_req_ready", 448'(bus.req_ready), 448'd0);
    rv = '0;
    resetn = 1'b1;

    // Basic subtract from requester 2
    issue(2, 448'd5, 448'd3);
    step();
    chk("basic_valid", 448'(bus.rsp_valid), 448'd1);
    chk("basic_tag", 448'(bus.rsp_tag), 448'd2);
    chk("basic_z", bus.rsp_z, 448'd2);
    step();

    // Wrap-around and boundary operands
    issue(1, 448'd3, 448'd5);
    issue(3, 448'd0, 448'd0);
    chk("wrap_z", bus.rsp_z, pm2);
    issue(0, pm1, 448'd0);
    chk("zero_z", bus.rsp_z, 448'd0);
    step();
    chk("pm1_z", bus.rsp_z, pm1);
    repeat (2) step();

    // Contention: all requesters held, consumer always ready
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = 448'(i + 10);
      rb[i] = 448'(i);
    end
    rv = '1;
    rr = 1'b1;
    repeat (12) step();
    rv = '0;
    repeat (3) step();

    // Backpressure: three requests, consumer stalls for several cycles
    for (int i = 0; i < 3; i++) begin
      ra[i] = rnd_fe();
      rb[i] = rnd_fe();
      pend[i] = 1'b1;
    end
    rr = 1'b0;
    repeat (7) begin drive_pend(); step(); end
    rr = 1'b1;
    repeat (6) begin drive_pend(); step(); end

    // Withdrawal: requester 1 asks while stalled, then gives up
    ra[0] = rnd_fe();
    rb[0] = rnd_fe();
    pend[0] = 1'b1;
    rr = 1'b0;
    repeat (3) begin drive_pend(); step(); end
    in_withdraw = 1'b1;
    ra[1] = rnd_fe();
    rb[1] = rnd_fe();
    pend[1] = 1'b1;
    repeat (2) begin drive_pend(); step(); end
    pend[1] = 1'b0;
    drive_pend();
    step();
    rr = 1'b1;
    repeat (4) begin drive_pend(); step(); end
    in_withdraw = 1'b0;
    chk("withdraw_tag1", 448'(seen_tag1), 448'd0);

    // Reset mid-operation with two operations in flight
    ra[2] = rnd_fe(); rb[2] = rnd_fe(); pend[2] = 1'b1;
    ra[3] = rnd_fe(); rb[3] = rnd_fe(); pend[3] = 1'b1;
    rr = 1'b0;
    repeat (3) begin drive_pend(); step(); end
    resetn = 1'b0;
    #1;
    chk("midrst_rsp_valid", 448'(bus.rsp_valid), 448'd0);
    chk("midrst_busy", 448'(bus.busy), 448'd0);
    chk("midrst_req_ready", 448'(bus.req_ready), 448'd0);
    chk("midrst_rsp_z", bus.rsp_z, 448'd0);
    q.delete();
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    rv = '0;
`ifdef SUBMOD_ARB_RR_EN
    last = NREQ - 1;
`endif
    @(posedge clk);
    cyc++;
    #1;
    resetn = 1'b1;
    rr = 1'b1;
    repeat (3) step();
    issue(2, 448'd100, 448'd1);
    step();
    chk("fresh_valid", 448'(bus.rsp_valid), 448'd1);
    chk("fresh_tag", 448'(bus.rsp_tag), 448'd2);
    chk("fresh_z", bus.rsp_z, 448'd99);
    step();

    // Randomized traffic with random backpressure and withdrawals
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          ra[i] = rnd_fe();
          rb[i] = rnd_fe();
        end else if (pend[i] && $urandom_range(19) == 0) begin
          pend[i] = 1'b0;
        end
      end
      rr = ($urandom_range(3) != 0);
      drive_pend();
      step();
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    rv = '0;
    rr = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/submod_arb.md
# submod_arb

Arbitrated, pipelined front end for the 448-bit modular subtractor, z = (a − b) mod p with p = 2^448 − 2^224 − 1. NREQ requesters share one subtractor instance. Each requester has a valid/ready request channel, and a single tagged response channel returns results in issue order. The block sits between the X448 ladder step sequencers and the shared field-arithmetic datapath.

## Interface
- NREQ, 4: number of requesters (2..8).
- TAGW, 2: response tag width; must satisfy 2^TAGW ≥ NREQ.
- clk  in  1  sole clock; all state updates on its rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- req_valid  in  NREQ  request i presents operands.
- req_ready  out  NREQ  one-hot or zero; request i accepted on an edge where req_valid[i] & req_ready[i].
- req_a  in  NREQ*448  operand a of requester i in bits [448*i+447 : 448*i].
- req_b  in  NREQ*448  operand b, same packing.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_tag  out  TAGW  index of the requester that issued the response.
- rsp_z  out  448  (a − b) mod p.
- busy  out  1  high while any pipeline stage holds a valid entry.

## Operation
- Pipeline stage S1 registers the granted a, b, tag and a valid bit.
- S1 drives the combinational subtractor. The result is registered in stage S2, which holds z, tag and a valid bit.
- S2 drives rsp_valid, rsp_tag and rsp_z.
- advance = !S2.valid | rsp_ready.
  - When advance is high, S2 loads from S1 and S1 loads from the granted request; S1 loads a bubble if there is no grant.
  - When advance is low, both stages hold.
- Grant is combinational from req_valid and the priority state.
- req_ready[g] = advance for the granted index g. All other req_ready bits are 0.
- The arbiter never grants a requester whose req_valid is 0.
- Requesters hold req_valid and operands stable until accepted. Dropping req_valid before acceptance is permitted; it withdraws the request with no side effect.
- Arithmetic:
  - Operands must be canonical, in [0, p).
  - z = a − b if a ≥ b, else a − b + p. The result is always canonical.
  - For non-canonical inputs, z is the subtractor's raw result modulo 2^448. It is not checked.
- Responses leave strictly in acceptance order. The tag equals the requester index, zero-extended to TAGW.
- Simultaneous response pop and new request in one cycle is permitted, giving full throughput of one operation per cycle.
- busy = S1.valid | S2.valid.

## Timing
- Reset values: rsp_valid = 0, busy = 0, rsp_tag = 0, rsp_z = 0, req_ready = 0 while resetn is low. All valid bits clear and the round-robin pointer is set to NREQ−1.
- Reset asserted mid-operation flushes both stages immediately and asynchronously. In-flight results are lost and no partial response is emitted.
- First grant is possible on the first rising edge after resetn deasserts.
- Latency:
  - Request accepted at edge k → S1 valid after edge k → S2 valid after edge k+1.
  - rsp_valid is therefore high in the cycle after edge k+1: 2 cycles from acceptance.
- Backpressure:
  - With rsp_ready held low and S2 full, rsp_valid, rsp_tag and rsp_z stay stable.
  - S1 holds its entry and all req_ready bits are 0 until rsp_ready returns high.
  - No entry is dropped or duplicated.
- Pipeline capacity is 2 outstanding operations.

## Configuration
- SUBMOD_ARB_RR_EN defined: round-robin arbitration.
  - After a grant to index g is accepted, the pointer becomes g.
  - The next search starts at (g+1) mod NREQ.
  - The pointer updates only on an accepted handshake, not on a stalled grant.
- SUBMOD_ARB_RR_EN undefined: fixed priority. The lowest valid index always wins and the pointer logic is not built.

## Test plan
- Basic subtract: a=5, b=3 from requester 2 → after 2 cycles rsp_valid=1, rsp_tag=2, rsp_z=2.
- Wrap: a=3, b=5 → rsp_z = p − 2. Also a=0, b=0 → 0, and a=p−1, b=0 → p−1.
- Contention: all 4 req_valid held high with rsp_ready=1, operands a=i+10, b=i.
  - With SUBMOD_ARB_RR_EN: tags 0,1,2,3,0,1… one per cycle, each rsp_z=10.
  - Without SUBMOD_ARB_RR_EN: tag 0 every cycle.
- Backpressure: issue 3 back-to-back requests, hold rsp_ready=0 for 5 cycles.
  - rsp_valid stays 1 with z and tag unchanged.
  - req_ready=0 once 2 entries are in flight.
  - After release, all 3 responses arrive in order, none lost.
- Withdrawal: requester 1 raises req_valid while stalled, then drops it before acceptance → no response with tag 1 appears.
- Reset mid-op: two operations in flight, pulse resetn low for 1 cycle → rsp_valid=0 and busy=0 immediately, no stale response afterward, and a fresh request completes correctly in 2 cycles.
